imem_load_arbiter: RTL and testbench

Controller that shares the single-port instruction memory between the fetch unit and a UART program loader. In run mode, the fetch word address drives the memory and the read word goes to fetch. In load mode, the CPU is held and a length-prefixed byte stream is assembled into 32-bit words and written from word 0 upward. The block sits between the UART receiver, the fetch stage and the instruction memory. It is the only writer of instruction memory.

---
 rtl/imem_load_pkg.sv | 18 +
 rtl/imem_load_arbiter_byte_word_assembler.sv | 32 +++
 rtl/imem_load_arbiter.sv | 121 ++++++++++++
 tb/tb_imem_load_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_pkg.sv
// Shared constants for the instruction-memory load arbiter: FSM state
// encodings, loader framing sizes and the instruction fetched while held.
package imem_load_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN    = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_LEN_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

endpackage

// File: rtl/imem_load_arbiter_byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. The completed word is
// presented combinationally in the same cycle as its last byte.
module byte_word_assembler
  import imem_load_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] shift;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane  <= 2'd0;
      shift <= 24'd0;
    end else if (rx_valid) begin
      lane  <= lane + 2'd1;
      shift <= {rx_byte, shift[23:8]};
    end
  end

  // The oldest byte has drifted to the bottom, so byte k lands in bits [8k+7:8k].
  assign word       = {rx_byte, shift};
  assign word_valid = rx_valid && (lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction memory between fetch (run mode) and a UART loader
// that writes a length-prefixed byte stream from word 0 upward.
module imem_load_arbiter
  import imem_load_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic [31:0]       instr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_rx;
  logic [IDLE_W-1:0] idle_cnt;
  logic              receiving;
  logic              idle_expired;
  logic              last_word;
  logic              in_data;
  logic [31:0]       word;
  logic              word_valid;

  assign in_data      = (state == ST_DATA);
  assign receiving    = (state == ST_LEN_LO) || (state == ST_LEN_HI) || in_data;
  assign idle_expired = receiving && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign len_rx       = {rx_byte, len[7:0]};
  assign last_word    = (32'(words_loaded) + 32'd1) == 32'(len);

  // Leaving DATA for any reason drops a partially assembled word.
  byte_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (!in_data),
    .rx_valid   (rx_valid && in_data),
    .rx_byte    (rx_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_RUN;
      len          <= '0;
      idle_cnt     <= '0;
      words_loaded <= '0;
      mem_wdata    <= 32'd0;
      mem_we       <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      mem_we   <= word_valid;
      load_err <= 1'b0;
      if (word_valid) mem_wdata <= word;
      if (mem_we) words_loaded <= words_loaded + 1'b1;

      if (!receiving || rx_valid) idle_cnt <= '0;
      else                        idle_cnt <= idle_cnt + 1'b1;

      if (idle_expired) begin
        state    <= ST_RUN;
        load_err <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (load_start) begin
              state        <= ST_LEN_LO;
              words_loaded <= '0;
            end
          end
          ST_LEN_LO: begin
            if (rx_valid) begin
              len[7:0] <= rx_byte;
              state    <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (rx_valid) begin
              len <= len_rx;
              // Capping N at the memory depth is what keeps the write index from wrapping.
              if (32'(len_rx) > (32'd1 << ADDR_W)) begin
                state    <= ST_RUN;
                load_err <= 1'b1;
              end else if (len_rx == '0) begin
                state <= ST_FINISH;
              end else begin
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (mem_we && last_word) state <= ST_FINISH;
          end
          ST_FINISH: state <= ST_RUN;
          default:   state <= ST_RUN;
        endcase
      end
    end
  end

  assign cpu_hold  = (state != ST_RUN);
  assign load_done = (state == ST_FINISH);
  assign mem_addr  = cpu_hold ? words_loaded[ADDR_W-1:0] : fetch_addr;
  assign instr     = cpu_hold ? NOP_INSTR : mem_rdata;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a synchronous-read memory model
// and a negedge monitor that timestamps writes, done/err pulses and hold release.
module tb_imem_load_arbiter;
  import imem_load_pkg::*;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_start;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       instr;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset
  always #5 clock = ~clock;

  imem_load_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_start   (load_start),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .fetch_addr   (fetch_addr),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .instr        (instr),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // single-port memory, 1-cycle synchronous read
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // negedge monitor
  int cyc = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_we_cyc = -1, done_cyc = -1, err_cyc = -1, fall_cyc = -1, last_rx_cyc = -1;
  logic hold_prev = 1'b0;
  always @(negedge clock) begin
    cyc++;
    if (mem_we)    begin we_cnt++;   last_we_cyc = cyc; end
    if (load_done) begin done_cnt++; done_cyc = cyc;    end
    if (load_err)  begin err_cnt++;  err_cyc = cyc;     end
    if (rx_valid)  last_rx_cyc = cyc;
    if (hold_prev && !cpu_hold) fall_cyc = cyc;
    hold_prev = cpu_hold;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int i = 0; i < 40 && done_cnt == prev; i++) tick();
    check(tag, 64'(done_cnt), 64'(prev + 1));
  endtask

  task automatic wait_err(input string tag, input int prev);
    for (int i = 0; i < 40 && err_cnt == prev; i++) tick();
    check(tag, 64'(err_cnt), 64'(prev + 1));
  endtask

  int we0, done0, err0;
  logic [7:0] burst [0:4];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; fetch_addr = '0;
    tick(); tick();

    // reset state
    check("rst_hold", 64'(cpu_hold), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_state", 64'(dut.state), 64'(ST_RUN));
    reset = 1'b0;
    tick();

    // run passthrough
    mem[5] = 32'h2008_0001;
    fetch_addr = 14'd5;
    #1;
    check("run_addr", 64'(mem_addr), 64'd5);
    tick();
    check("run_instr", 64'(instr), 64'h2008_0001);
    check("run_no_we", 64'(we_cnt), 64'd0);

    // rx byte in RUN ignored
    send_byte(8'hAA);
    check("run_rx_hold", 64'(cpu_hold), 64'd0);
    check("run_rx_words", 64'(words_loaded), 64'd0);

    // load two words
    done0 = done_cnt;
    pulse_start();
    check("ld_hold", 64'(cpu_hold), 64'd1);
    check("ld_nop", 64'(instr), 64'h0);
    check("ld_addr", 64'(mem_addr), 64'd0);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_done("ld_done", done0);
    tick(); tick();
    check("ld_we_cnt", 64'(we_cnt), 64'd2);
    check("ld_mem0", 64'(mem[0]), 64'h1234_5678);
    check("ld_mem1", 64'(mem[1]), 64'hDEAD_BEEF);
    check("ld_words", 64'(words_loaded), 64'd2);
    check("ld_done_lat", 64'(done_cyc), 64'(last_we_cyc + 1));
    check("ld_fall_lat", 64'(fall_cyc), 64'(last_we_cyc + 2));
    check("ld_hold_off", 64'(cpu_hold), 64'd0);

    // zero length
    we0 = we_cnt; done0 = done_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    wait_done("zero_done", done0);
    tick();
    check("zero_no_we", 64'(we_cnt), 64'(we0));
    check("zero_words", 64'(words_loaded), 64'd0);
    check("zero_hold", 64'(cpu_hold), 64'd0);

    // oversize N = 0x4001
    we0 = we_cnt; err0 = err_cnt;
    pulse_start();
    send_byte(8'h01); send_byte(8'h40);
    wait_err("big_err", err0);
    tick();
    check("big_no_we", 64'(we_cnt), 64'(we0));
    check("big_hold", 64'(cpu_hold), 64'd0);
    check("big_state", 64'(dut.state), 64'(ST_RUN));

    // timeout after partial word
    we0 = we_cnt; err0 = err_cnt;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
    wait_err("to_err", err0);
    tick();
    check("to_lat", 64'(err_cyc), 64'(last_rx_cyc + TIMEOUT + 1));
    check("to_words", 64'(words_loaded), 64'd0);
    check("to_no_we", 64'(we_cnt), 64'(we0));
    check("to_hold", 64'(cpu_hold), 64'd0);

    // back-to-back bytes; load_start mid-load must be ignored
    done0 = done_cnt;
    pulse_start();
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h00);
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1;
      rx_byte  = burst[i];
      tick();
    end
    rx_valid = 1'b0;
    tick();
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    wait_done("b2b_done", done0);
    tick(); tick();
    check("b2b_mem0", 64'(mem[0]), 64'h4433_2211);
    check("b2b_mem1", 64'(mem[1]), 64'h8877_6655);
    check("b2b_words", 64'(words_loaded), 64'd2);

    // reset in DATA after five bytes
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4); send_byte(8'hE5);
    reset = 1'b1;
    load_start = 1'b1;
    tick();
    check("mid_rst_state", 64'(dut.state), 64'(ST_RUN));
    check("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_we", 64'(mem_we), 64'd0);
    reset = 1'b0;
    load_start = 1'b0;
    fetch_addr = 14'd0;
    tick();
    check("mid_rst_mem0", 64'(mem[0]), 64'hD4C3_B2A1);
    check("mid_rst_instr", 64'(instr), 64'hD4C3_B2A1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
